// File: rtl/smart_home_pkg.sv
// smart_home_pkg: constants and the temperature-path state type shared by the
// sensor conditioning blocks.
package smart_home_pkg;

   localparam int ST_W = 7;
   localparam logic [ST_W-1:0] ST_RESET = 7'd25;
   localparam int REJECT_LIMIT = 3;

   // Temperature path: UNPRIMED until the first valid sample seeds the history.
   typedef enum logic {
      UNPRIMED = 1'b0,
      PRIMED   = 1'b1
   } st_state_e;

   // Unsigned distance between two temperature samples.
   function automatic logic [ST_W-1:0] abs_diff(input logic [ST_W-1:0] a,
                                                input logic [ST_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer followed by a stability counter.
// The output takes the synchronized level once it has differed from the
// output for DEB_CYCLES consecutive edges; any agreement clears the count.
module sensor_debounce
   import smart_home_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic Rst,
   input  logic i_raw,
   output logic o_level
);

   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   logic       r_sync1;
   logic       r_sync2;
   logic [7:0] r_cnt;
   logic       r_level;

   // Synchronize the raw contact and debounce the synchronized level.
   always_ff @(posedge clk) begin
      if (!Rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == DEB_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: debounces four door/window/fire contacts and conditions
// a temperature stream (priming, step-plausibility check, sticky fault).
// Build option: define SENSOR_AVG_EN to make ST the average of the last four
// accepted samples; otherwise ST is simply the last accepted sample.
module sensor_conditioner
   import smart_home_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int MAX_STEP   = 10
) (
   input  logic            clk,
   input  logic            Rst,
   input  logic            raw_sfd,
   input  logic            raw_srd,
   input  logic            raw_sw,
   input  logic            raw_sfa,
   input  logic [ST_W-1:0] raw_st,
   input  logic            st_valid,
   output logic            SFD,
   output logic            SRD,
   output logic            SW,
   output logic            SFA,
   output logic [ST_W-1:0] ST,
   output logic            st_fault
);

   localparam logic [31:0] MAX_STEP_U = MAX_STEP;
   localparam logic [1:0]  REJ_MAX    = 2'(REJECT_LIMIT);

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sfd (.clk(clk), .Rst(Rst), .i_raw(raw_sfd), .o_level(SFD));
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_srd (.clk(clk), .Rst(Rst), .i_raw(raw_srd), .o_level(SRD));
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw  (.clk(clk), .Rst(Rst), .i_raw(raw_sw),  .o_level(SW));
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sfa (.clk(clk), .Rst(Rst), .i_raw(raw_sfa), .o_level(SFA));

   st_state_e       r_state;
   logic [ST_W-1:0] r_st;
   logic [1:0]      r_rej;
   logic            r_fault;
   logic [ST_W-1:0] w_diff;
   logic            w_accept;

   // Plausibility: a primed sample must lie within MAX_STEP of the current ST.
   assign w_diff   = abs_diff(raw_st, r_st);
   assign w_accept = (32'(w_diff) <= MAX_STEP_U);

`ifdef SENSOR_AVG_EN
   logic [ST_W-1:0] r_hist [4];
   logic [8:0]      w_sum;

   // Sum of the incoming sample and the three newest history entries, i.e.
   // the history as it will be after this sample is shifted in.
   assign w_sum = 9'(raw_st) + 9'(r_hist[0]) + 9'(r_hist[1]) + 9'(r_hist[2]);
`endif

   // Temperature FSM: prime on the first sample, then accept or reject by step.
   always_ff @(posedge clk) begin
      if (!Rst) begin
         r_state <= UNPRIMED;
         r_st    <= ST_RESET;
         r_rej   <= '0;
         r_fault <= 1'b0;
`ifdef SENSOR_AVG_EN
         for (int i = 0; i < 4; i++) r_hist[i] <= '0;
`endif
      end else if (st_valid) begin
         case (r_state)
            UNPRIMED: begin
               r_st    <= raw_st;
               r_state <= PRIMED;
`ifdef SENSOR_AVG_EN
               for (int i = 0; i < 4; i++) r_hist[i] <= raw_st;
`endif
            end
            PRIMED: begin
               if (w_accept) begin
                  r_rej <= '0;
`ifdef SENSOR_AVG_EN
                  r_hist[0] <= raw_st;
                  r_hist[1] <= r_hist[0];
                  r_hist[2] <= r_hist[1];
                  r_hist[3] <= r_hist[2];
                  r_st      <= w_sum[8:2];
`else
                  r_st      <= raw_st;
`endif
               end else begin
                  if (r_rej != REJ_MAX) r_rej <= r_rej + 2'd1;
                  // The reject that brings the count to the limit raises the fault.
                  if (r_rej >= REJ_MAX - 2'd1) r_fault <= 1'b1;
               end
            end
            default: r_state <= UNPRIMED;
         endcase
      end
   end

   assign ST       = r_st;
   assign st_fault = r_fault;

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: cycles a synchronized input must be stable before its output changes (range 2..255).
REQ-002 SHALL have parameter MAX_STEP, default 10: maximum accepted |new sample - ST| once primed.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports raw_sfd, raw_srd, raw_sw, raw_sfa, each input, 1: asynchronous raw sensor contacts (front door, rear door, window, fire alarm).
REQ-006 SHALL have port raw_st, input, 7: raw temperature sample, unsigned degrees.
REQ-007 SHALL have port st_valid, input, 1: raw_st is valid this cycle.
REQ-008 SHALL have ports SFD, SRD, SW, SFA, each output, 1: debounced sensor levels for the downstream controller.
REQ-009 SHALL have port ST, output, 7: conditioned temperature.
REQ-010 SHALL have port st_fault, output, 1: sticky flag for implausible temperature stream.

Function
REQ-011 Each raw_* contact SHALL pass a 2-flop synchronizer, then a debounce counter.
REQ-012 Debounce: counter clears whenever the synchronized value equals the output; otherwise it increments; when it reaches DEB_CYCLES-1 while still differing, the output takes the synchronized value on that edge.
REQ-013 Output latency for a clean step SHALL be exactly 2 + DEB_CYCLES cycles from the input change to the output change.
REQ-014 A glitch shorter than DEB_CYCLES synchronized cycles SHALL leave the output unchanged and clear the counter.
REQ-015 The four debounce channels SHALL operate independently; simultaneous changes SHALL update in the same cycle.
REQ-016 Temperature path SHALL have two states: UNPRIMED (after reset) and PRIMED.
REQ-017 In UNPRIMED, the first st_valid sample SHALL be written to all four history entries, ST SHALL equal it on the next cycle, and the state SHALL become PRIMED; no step check applies.
REQ-018 In PRIMED, a sample with |raw_st - ST| <= MAX_STEP SHALL be accepted: shifted into the 4-entry history with the oldest dropped; ST updates on the following cycle.
REQ-019 A sample exceeding MAX_STEP SHALL be rejected: history and ST unchanged; reject counter increments (saturates at 3).
REQ-020 An accepted sample SHALL clear the reject counter; 3 consecutive rejects SHALL set st_fault, which stays high until reset.
REQ-021 Averaging arithmetic: 9-bit sum of 4 entries, ST = sum[8:2] (truncation, no rounding, no overflow).
REQ-022 st_valid low SHALL hold ST, history, and counters unchanged.

Reset
REQ-023 On a clk edge with Rst=0: SFD/SRD/SW/SFA=0, synchronizers and debounce counters=0, ST=7'd25, history=0, state=UNPRIMED, reject counter=0, st_fault=0.
REQ-024 Reset mid-debounce or mid-stream SHALL discard all progress; the first post-reset sample SHALL prime again.

Configuration
REQ-025 Macro SENSOR_AVG_EN defined: ST SHALL be the 4-sample average per REQ-021.
REQ-026 SENSOR_AVG_EN undefined: history logic SHALL be absent; ST SHALL be the last accepted sample, with step check, priming, and fault unchanged.

Structure
REQ-027 Shared package smart_home_pkg SHALL hold ST_W=7, ST_RESET=7'd25, REJECT_LIMIT=3, and the UNPRIMED/PRIMED state enum.
REQ-028 Sub-module sensor_debounce (synchronizer + counter, parameter DEB_CYCLES) SHALL be instantiated four times.

Verification
REQ-029 raw_sfd 0->1 held, DEB_CYCLES=4 -> SFD rises exactly 6 cycles later.
REQ-030 raw_sw pulse of 2 cycles, DEB_CYCLES=4 -> SW stays 0; counter returns to 0.
REQ-031 After reset, sample 30 -> ST=30 next cycle; then samples 34, 34, 34, 34 -> ST sequence 31, 32, 33, 34 (SENSOR_AVG_EN defined).
REQ-032 PRIMED at ST=30, samples 50, 50, 50 -> ST stays 30, st_fault=1 after the third; a subsequent sample 31 -> st_fault remains 1.
REQ-033 Samples 50, 31, 50, 50 from ST=30 -> 31 is accepted, reject counter clears, st_fault stays 0.
REQ-034 Rst=0 for one cycle mid-stream with SFA=1, ST=40 -> next cycle SFA=0, ST=25, UNPRIMED; next sample 80 -> ST=80 with no rejection.
